// File: rtl/link_monitor.sv
// link_monitor: multi-channel LL/SC reservation monitor gating conditional stores and snooping plain stores
// Define LINK_TIMEOUT_EN to expire reservations after TIMEOUT cycles.
module link_monitor #(
  parameter int BITS = 32,
  parameter int NUM_CH = 4,
  parameter int CH_BITS = 2,
  parameter int GRAN_BITS = 0,
  parameter int TIMEOUT = 255,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [CH_BITS-1:0]  ch_id,
  input  logic [BITS-1:0]     addr,
  input  logic                load_link_,
  input  logic                check_link,
  input  logic                mem_rw_,
  output logic                use_mem_rw_,
  output logic                sc_success,
  output logic [NUM_CH-1:0]   link_valid,
  output logic [CNT_BITS-1:0] sc_fail_cnt
);
  logic [BITS-1:0]   resv_addr [NUM_CH];
  logic [NUM_CH-1:0] sel, match, set, clr, expire;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel[c]   = ch_id == CH_BITS'(c);
    assign match[c] = link_valid[c] && addr[BITS-1:GRAN_BITS] == resv_addr[c][BITS-1:GRAN_BITS];
  end
  // an out-of-range ch_id leaves sel all-zero, so it can neither link nor succeed
  assign sc_success  = check_link && |(sel & match);
  assign use_mem_rw_ = check_link ? ~sc_success : mem_rw_;
  assign set = (!check_link && !load_link_) ? sel : '0;
  assign clr = check_link ? (sel | (sc_success ? match : '0)) : (!mem_rw_ ? match : '0);
`ifdef LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr [NUM_CH];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_exp
    assign expire[c] = link_valid[c] && tmr[c] == TW'(TIMEOUT);
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_)
      for (int c = 0; c < NUM_CH; c++) tmr[c] <= '0;
    else
      for (int c = 0; c < NUM_CH; c++)
        tmr[c] <= set[c] ? '0 : (link_valid[c] && tmr[c] != TW'(TIMEOUT)) ? tmr[c] + 1'b1 : tmr[c];
`else
  assign expire = '0;
`endif
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      link_valid  <= '0;
      sc_fail_cnt <= '0;
      for (int c = 0; c < NUM_CH; c++) resv_addr[c] <= '0;
    end else begin
      link_valid <= set | (link_valid & ~clr & ~expire);
      for (int c = 0; c < NUM_CH; c++)
        if (set[c]) resv_addr[c] <= addr;
      if (check_link && !sc_success && sc_fail_cnt != '1) sc_fail_cnt <= sc_fail_cnt + 1'b1;
    end
endmodule

// File: tb/tb_link_monitor.sv
// tb_link_monitor: randomized LL/SC traffic checked against a behavioural reservation model
module tb_link_monitor;
  localparam int NCH = 4, G = 2, TO = 4;
  logic clk = 0, rst_ = 0;
  logic [2:0] ch_id = '0;
  logic [31:0] addr = '0;
  logic load_link_ = 1, check_link = 0, mem_rw_ = 1;
  logic use_mem_rw_, sc_success;
  logic [NCH-1:0] link_valid;
  logic [1:0] sc_fail_cnt;
  int errs = 0, checks = 0;
  bit mv [NCH];
  logic [31:0] ma [NCH];
  int age [NCH];
  int mcnt;

  link_monitor #(.BITS(32), .NUM_CH(NCH), .CH_BITS(3), .GRAN_BITS(G), .TIMEOUT(TO), .CNT_BITS(2)) dut (
    .clk(clk), .rst_(rst_), .ch_id(ch_id), .addr(addr), .load_link_(load_link_), .check_link(check_link),
    .mem_rw_(mem_rw_), .use_mem_rw_(use_mem_rw_), .sc_success(sc_success), .link_valid(link_valid),
    .sc_fail_cnt(sc_fail_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit same_gran(input logic [31:0] a, input logic [31:0] b);
    return (a >> G) == (b >> G);
  endfunction

  function automatic logic [31:0] exp_lv();
    logic [31:0] v = '0;
    for (int c = 0; c < NCH; c++) v[c] = mv[c];
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin mv[c] = 0; ma[c] = '0; age[c] = 0; end
    mcnt = 0;
  endfunction

  // one memory op per cycle; inputs driven 1 time unit after a rising edge
  task automatic do_op(input int ch, input logic [31:0] a, input logic ll_n, input logic cl, input logic rw);
    bit ok, hit;
    bit pv [NCH];
    bit expd [NCH];
    bit rel [NCH];
    ch_id = 3'(ch); addr = a; load_link_ = ll_n; check_link = cl; mem_rw_ = rw;
    ok = ch < NCH;
    hit = cl && ok && mv[ch] && same_gran(a, ma[ch]);
    #1;
    check("sc_success", 32'(sc_success), 32'(hit));
    check("use_mem_rw_", 32'(use_mem_rw_), 32'(cl ? !hit : rw));
    for (int c = 0; c < NCH; c++) begin
      pv[c] = mv[c]; rel[c] = 0;
      expd[c] = mv[c] && age[c] == TO;
    end
    if (cl) begin
      if (!hit) mcnt = (mcnt == 3) ? 3 : mcnt + 1;
      if (hit) for (int c = 0; c < NCH; c++) if (mv[c] && same_gran(a, ma[c])) mv[c] = 0;
      if (ok) mv[ch] = 0;
    end else if (!ll_n) begin
      if (ok) begin mv[ch] = 1; ma[ch] = a; rel[ch] = 1; end
    end else if (!rw) begin
      for (int c = 0; c < NCH; c++) if (mv[c] && same_gran(a, ma[c])) mv[c] = 0;
    end
`ifdef LINK_TIMEOUT_EN
    for (int c = 0; c < NCH; c++)
      if (rel[c]) age[c] = 0;
      else if (pv[c]) begin
        if (expd[c]) mv[c] = 0;
        else age[c]++;
      end
`endif
    @(posedge clk);
    #1;
    check("link_valid", 32'(link_valid), exp_lv());
    check("sc_fail_cnt", 32'(sc_fail_cnt), 32'(mcnt));
  endtask

  task automatic ll(input int ch, input logic [31:0] a); do_op(ch, a, 0, 0, 1); endtask
  task automatic sc(input int ch, input logic [31:0] a); do_op(ch, a, 1, 1, 1); endtask
  task automatic st(input int ch, input logic [31:0] a); do_op(ch, a, 1, 0, 0); endtask
  task automatic ld(); do_op(0, 32'h0, 1, 0, 1); endtask

  task automatic mid_reset();
    #2 rst_ = 0;
    #1;
    check("rst_link_valid", 32'(link_valid), 32'h0);
    check("rst_sc_fail_cnt", 32'(sc_fail_cnt), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst_ = 1;
  endtask

  initial begin
    int r;
    logic [31:0] a;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_ = 1;
    check("reset_link_valid", 32'(link_valid), 32'h0);
    check("reset_sc_fail_cnt", 32'(sc_fail_cnt), 32'h0);
    ll(0, 32'h100); sc(0, 32'h100);
    check("ll_sc_pair", 32'(link_valid[0]), 32'h0);
    ll(0, 32'h200); ll(1, 32'h200); sc(1, 32'h200); sc(0, 32'h200);
    check("stolen_cnt", 32'(sc_fail_cnt), 32'h1);
    ll(2, 32'h40); st(3, 32'h43);
    check("gran_hit", 32'(link_valid[2]), 32'h0);
    ll(2, 32'h40); st(3, 32'h44);
    check("gran_miss", 32'(link_valid[2]), 32'h1);
    do_op(1, 32'h80, 0, 1, 1);
    check("ll_sc_both", 32'(link_valid[1]), 32'h0);
    ll(0, 32'h300);
    sc(5, 32'h300);
    check("bad_ch", 32'(link_valid), 32'h5);
    sc(5, 32'h0); sc(5, 32'h0); sc(5, 32'h0);
    check("cnt_sat", 32'(sc_fail_cnt), 32'h3);
    mid_reset();
    sc(0, 32'h300);
    ll(0, 32'h100); repeat (4) ld(); sc(0, 32'h100);
    ll(0, 32'h100); repeat (5) ld(); sc(0, 32'h100);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      a = 32'h40 + 32'($urandom_range(0, 11));
      if (r < 2) mid_reset();
      else if (r < 35) ll($urandom_range(0, 5), a);
      else if (r < 62) sc($urandom_range(0, 5), a);
      else if (r < 80) st($urandom_range(0, 5), a);
      else if (r < 84) do_op($urandom_range(0, 5), a, 0, 1, 1);
      else ld();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
